// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the combinational ROM address, buffers {pc, instr}
// pairs in a small prefetch queue and hands them to decode over valid/ready.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] iAddr,
   input  logic [31:0] iData,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fault
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QDEPTH);

   logic [31:0]      fetch_pc;
   logic [31:0]      pc_q    [QDEPTH];
   logic [31:0]      instr_q [QDEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             pop;
   logic             push;

   assign iAddr     = fetch_pc;
   assign out_valid = (count != '0) && !fault;
   assign out_pc    = out_valid ? pc_q[head]    : 32'h0;
   assign out_instr = out_valid ? instr_q[head] : 32'h0;

   assign pop  = out_valid && out_ready;
   // A pop in the same cycle frees a slot, so a full queue keeps streaming without a bubble.
   assign push = fetch_en && !fault && !redirect_valid && ((count < DEPTH_C) || pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         fault    <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         fault    <= |redirect_pc[1:0];
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            tail     <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + (PTR_W+1)'(1);
         end else if (pop && !push) begin
            count <= count - (PTR_W+1)'(1);
         end
      end
   end

   // Payload needs no reset: outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail]    <= fetch_pc;
         instr_q[tail] <= iData;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 64-word combinational ROM.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] iAddr;
   logic [31:0] iData;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fault;

   logic [31:0] rom [64];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign iData = rom[iAddr[7:2]];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n), .iAddr(iAddr), .iData(iData),
      .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .fault(fault)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
      rom[0] = 32'h0000_0593;
      rom[1] = 32'h00A5_A023;
      rom[2] = 32'h0005_A683;

      reset_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      #12;
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_iaddr", iAddr, 32'h0);
      check_val("rst_fault", 32'(fault), 32'd0);
      check_val("rst_out_pc", out_pc, 32'h0);

      // streaming after reset release
      @(posedge clk); #1; reset_n = 1'b1;
      tick();
      check_val("s0_valid", 32'(out_valid), 32'd1);
      check_val("s0_pc", out_pc, 32'h0);
      check_val("s0_instr", out_instr, 32'h0000_0593);
      tick();
      check_val("s1_pc", out_pc, 32'h4);
      check_val("s1_instr", out_instr, 32'h00A5_A023);
      tick();
      check_val("s2_pc", out_pc, 32'h8);
      check_val("s2_instr", out_instr, 32'h0005_A683);

      // saturation with decode stalled
      reset_n = 1'b0; out_ready = 1'b0; #2;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_val("full_iaddr", iAddr, 32'h8);
      check_val("full_pc", out_pc, 32'h0);
      out_ready = 1'b1;
      tick();
      check_val("drain_pc4", out_pc, 32'h4);
      tick();
      check_val("drain_pc8", out_pc, 32'h8);
      tick();
      check_val("drain_pc12", out_pc, 32'hC);
      check_val("drain_valid", 32'(out_valid), 32'd1);

      // redirect while full: queue holds 12,16
      out_ready = 1'b0;
      tick();
      redirect_to(32'h10);
      check_val("rd_flush_valid", 32'(out_valid), 32'd0);
      check_val("rd_iaddr", iAddr, 32'h10);
      out_ready = 1'b1;
      tick();
      check_val("rd_valid", 32'(out_valid), 32'd1);
      check_val("rd_pc", out_pc, 32'h10);
      check_val("rd_instr", out_instr, 32'hC0DE_0004);
      tick();
      check_val("rd_next_pc", out_pc, 32'h14);

      // misaligned redirect, refault, recovery
      redirect_to(32'h0E);
      check_val("mis_fault", 32'(fault), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check_val("mis_valid", 32'(out_valid), 32'd0);
         check_val("mis_iaddr", iAddr, 32'h0E);
         tick();
      end
      redirect_to(32'h22);
      check_val("refault", 32'(fault), 32'd1);
      redirect_to(32'h08);
      check_val("clr_fault", 32'(fault), 32'd0);
      check_val("clr_valid0", 32'(out_valid), 32'd0);
      tick();
      check_val("clr_valid1", 32'(out_valid), 32'd1);
      check_val("clr_pc", out_pc, 32'h8);
      check_val("clr_instr", out_instr, 32'h0005_A683);
      tick();
      check_val("clr_pc12", out_pc, 32'hC);

      // fetch disabled: drain, hold PC, resume
      fetch_en = 1'b0;
      tick();
      check_val("fe0_valid", 32'(out_valid), 32'd0);
      check_val("fe0_iaddr", iAddr, 32'h10);
      tick(); tick();
      check_val("fe0_hold", iAddr, 32'h10);
      fetch_en = 1'b1;
      tick();
      check_val("fe1_valid", 32'(out_valid), 32'd1);
      check_val("fe1_pc", out_pc, 32'h10);

      // back-to-back redirects, last wins
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect_to(32'h30);
      check_val("b2b_valid", 32'(out_valid), 32'd0);
      tick();
      check_val("b2b_pc", out_pc, 32'h30);
      check_val("b2b_instr", out_instr, 32'hC0DE_000C);

      // PC wrap at top of address space
      redirect_to(32'hFFFF_FFFC);
      tick();
      check_val("wrap_pc", out_pc, 32'hFFFF_FFFC);
      check_val("wrap_iaddr", iAddr, 32'h0);
      tick();
      check_val("wrap_next_pc", out_pc, 32'h0);
      check_val("wrap_instr", out_instr, 32'h0000_0593);

      // asynchronous reset mid-stream
      #3; reset_n = 1'b0; #1;
      check_val("arst_valid", 32'(out_valid), 32'd0);
      check_val("arst_iaddr", iAddr, 32'h0);
      reset_n = 1'b1;
      tick(); tick();
      redirect_to(32'h3);
      check_val("arst_pre_fault", 32'(fault), 32'd1);
      #3; reset_n = 1'b0; #1;
      check_val("arst_fault", 32'(fault), 32'd0);
      check_val("arst_iaddr2", iAddr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
